// File: rtl/mod8_counter_pkg.sv
// Shared definitions for the modulo-N counter: default geometry and the
// binary-to-Gray helper used by the counter datapath.
package mod8_counter_pkg;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_MODULUS = 8;
    localparam int DEF_WRAP_W  = 8;

    // Widest count the helper handles; callers zero-extend and truncate.
    localparam int GRAY_MAX_W  = 32;

    // Reflected binary Gray code: adjacent binary values map to codes that
    // differ in exactly one bit.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/mod8_counter_if.sv
// Observation bundle for the counter outputs. The counter drives it
// (master); consumers such as timebase users or monitors only read it (slave).
interface mod8_counter_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) ();

    logic [WIDTH-1:0]  count;
    logic              tc;
    logic [WIDTH-1:0]  count_gray;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output count,
        output tc,
        output count_gray,
        output wrap_cnt
    );

    modport slave (
        input count,
        input tc,
        input count_gray,
        input wrap_cnt
    );

endinterface

// File: rtl/mod8_counter_next.sv
// Combinational next-state logic for a modulo-MODULUS up-counter plus the
// terminal-count decode of the current state.
module mod_n_next
    import mod8_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             tc
);

    // Last legal state; the increment is steered back to zero here so the
    // count never walks into MODULUS..2**WIDTH-1.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Decode the terminal state and pick the wrapped or incremented successor.
    always_comb begin
        tc         = (count == LAST);
        count_next = tc ? '0 : count + ONE;
    end

endmodule

// File: rtl/mod8_counter.sv
// Free-running modulo-N up-counter with terminal-count flag, registered Gray
// copy of the count and a saturating wrap counter for debug visibility.
module mod8_counter
    import mod8_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS,
    parameter int WRAP_W  = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [WIDTH-1:0]  count_gray,
    output logic [WRAP_W-1:0] wrap_cnt
);

    // The count register must be able to hold every state 0..MODULUS-1.
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "mod8_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_next;
    logic             last;

    // Wrap counter sticks at all-ones instead of rolling over, so a large
    // value always means "at least this many wraps".
    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (v == '1) ? v : v + WRAP_W'(1);
    endfunction

    // Gray code of a count value, sized back down to the count width.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return WIDTH'(bin2gray(GRAY_MAX_W'(b)));
    endfunction

    mod_n_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count      (count),
        .count_next (count_next),
        .tc         (last)
    );

    // tc is a pure decode of the count register; it is low in reset because
    // the count is forced to zero and MODULUS is at least 2.
    assign tc = last;

    // Count, Gray copy and wrap counter advance together; reset wins over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            count_gray <= '0;
            wrap_cnt   <= '0;
        end else begin
            count      <= count_next;
            count_gray <= to_gray(count_next);
            if (last) begin
                wrap_cnt <= sat_inc(wrap_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mod8_counter.sv
// Scoreboard bench for mod8_counter: three instances (default, MODULUS=5,
// WRAP_W=4) share one clock and reset. The stimulus process drives rst on the
// falling edge and pushes the expected post-edge outputs; the monitor pops and
// compares shortly after each rising edge.
`timescale 1ns/1ps
module tb_mod8_counter;

    localparam int NI = 3;

    typedef struct packed {
        logic [2:0] cnt;
        logic       tc;
        logic [2:0] gray;
        logic [7:0] wrap;
        logic       step;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mod8_counter_if #(.WIDTH(3), .WRAP_W(8)) if_a ();
    mod8_counter_if #(.WIDTH(3), .WRAP_W(8)) if_b ();
    mod8_counter_if #(.WIDTH(3), .WRAP_W(4)) if_c ();

    mod8_counter #(.WIDTH(3), .MODULUS(8), .WRAP_W(8)) dut_a (
        .clk(clk), .rst(rst), .count(if_a.count), .tc(if_a.tc),
        .count_gray(if_a.count_gray), .wrap_cnt(if_a.wrap_cnt));
    mod8_counter #(.WIDTH(3), .MODULUS(5), .WRAP_W(8)) dut_b (
        .clk(clk), .rst(rst), .count(if_b.count), .tc(if_b.tc),
        .count_gray(if_b.count_gray), .wrap_cnt(if_b.wrap_cnt));
    mod8_counter #(.WIDTH(3), .MODULUS(8), .WRAP_W(4)) dut_c (
        .clk(clk), .rst(rst), .count(if_c.count), .tc(if_c.tc),
        .count_gray(if_c.count_gray), .wrap_cnt(if_c.wrap_cnt));

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int checks = 0;
    int passes = 0;

    // Reference model: edges since the last reset per instance. The count is
    // that number modulo MODULUS, the wraps are its quotient, clipped.
    int steps [NI];
    int mods  [NI] = '{8, 5, 8};
    int wmax  [NI] = '{255, 255, 15};
    bit started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input int i, input logic r);
        exp_t e;
        int c, w;
        c      = steps[i] % mods[i];
        w      = steps[i] / mods[i];
        if (w > wmax[i]) w = wmax[i];
        e.cnt  = 3'(c);
        e.tc   = (c == mods[i] - 1);
        e.gray = 3'(c ^ (c >> 1));
        e.wrap = 8'(w);
        e.step = !r && started;
        return e;
    endfunction

    // Drive one cycle of rst and record what the following rising edge must produce.
    task automatic apply(input logic r);
        @(negedge clk);
        rst = r;
        for (int i = 0; i < NI; i++) begin
            if (r) steps[i] = 0;
            else   steps[i] = steps[i] + 1;
        end
        qa.push_back(model(0, r));
        qb.push_back(model(1, r));
        qc.push_back(model(2, r));
        started = 1'b1;
    endtask

    // Monitor: compare every instance after each rising edge that has an expectation.
    logic [2:0] prev_ga, prev_gc;
    initial begin
        exp_t ea, eb, ec;
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                ec = qc.pop_front();
                chk("a.count",   int'(if_a.count),      int'(ea.cnt));
                chk("a.tc",      int'(if_a.tc),         int'(ea.tc));
                chk("a.gray",    int'(if_a.count_gray), int'(ea.gray));
                chk("a.wrap",    int'(if_a.wrap_cnt),   int'(ea.wrap));
                chk("b.count",   int'(if_b.count),      int'(eb.cnt));
                chk("b.tc",      int'(if_b.tc),         int'(eb.tc));
                chk("b.gray",    int'(if_b.count_gray), int'(eb.gray));
                chk("b.wrap",    int'(if_b.wrap_cnt),   int'(eb.wrap));
                chk("c.count",   int'(if_c.count),      int'(ec.cnt));
                chk("c.tc",      int'(if_c.tc),         int'(ec.tc));
                chk("c.gray",    int'(if_c.count_gray), int'(ec.gray));
                chk("c.wrap",    int'(if_c.wrap_cnt),   int'(ec.wrap));
                if (ea.step) begin
                    chk("a.gray_hamming", $countones(prev_ga ^ if_a.count_gray), 1);
                    chk("c.gray_hamming", $countones(prev_gc ^ if_c.count_gray), 1);
                end
                prev_ga = if_a.count_gray;
                prev_gc = if_c.count_gray;
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized reset pulses.
    initial begin
        for (int i = 0; i < NI; i++) steps[i] = 0;
        apply(1'b1);
        repeat (8) apply(1'b0);          // 1..7,0: one wrap
        repeat (4) apply(1'b0);          // count reaches 4
        apply(1'b1);                     // mid-count reset
        apply(1'b0);                     // back to 1
        repeat (6) apply(1'b0);          // count reaches 7
        apply(1'b1);                     // reset at terminal count: no wrap
        repeat (2) apply(1'b1);          // reset held
        repeat (80) apply(1'b0);         // ten wraps
        repeat (200) apply(1'b0);        // narrow wrap counter saturates
        for (int k = 0; k < 300; k++) begin
            apply(($urandom_range(15) == 0) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            apply(($urandom_range(1) == 0) ? 1'b1 : 1'b0);
        end
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", qa.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
